// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, fill count, sticky error flags
// and a selectable standard (1-cycle latency) or first-word-fall-through read port.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  CLR_ERR
);

    localparam int                PW      = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = PW'(1);
    localparam logic [ADDR_WIDTH:0] AF_THR  = PW'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_THR  = PW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_acc, rd_acc;

    always_comb begin
        wr_acc   = WR_EN && !full_q;
        rd_acc   = RD_EN && !empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        // Status is derived from the post-edge pointers so every flag lines up with COUNT.
        count_d = wr_ptr_d - rd_ptr_d;
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]) &&
                  (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
        af_d    = (count_d >= AF_THR);
        ae_d    = (count_d <= AE_THR);

        ovf_d = (WR_EN && full_q)  || (ovf_q && !CLR_ERR);
        udf_d = (RD_EN && empty_q) || (udf_q && !CLR_ERR);

        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (FWFT) begin
            // The new head bypasses memory when it is the word being written this cycle.
            if (wr_acc && (empty_q || (rd_acc && (rd_ptr_d == wr_ptr_q)))) begin
                rd_data_d = WR_DATA;
            end else if (rd_acc) begin
                rd_data_d = mem_q[rd_ptr_d[ADDR_WIDTH-1:0]];
            end
        end else begin
            rd_valid_d = rd_acc;
            if (rd_acc) begin
                rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign RD_DATA      = rd_data_q;
    assign RD_VALID     = FWFT ? !empty_q : rd_valid_q;
    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = af_q;
    assign ALMOST_EMPTY = ae_q;
    assign COUNT        = count_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = udf_q;

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO for buffering within one clock domain, e.g. between the register file/ALU and the UART TX path where no CDC is needed.
It generalises the existing FIFO:
- any power-of-two depth;
- programmable almost-full/almost-empty thresholds;
- a live fill count;
- sticky overflow/underflow error flags;
- selectable standard (1-cycle read latency) or first-word-fall-through (FWFT) read mode.

Parameters:
DATA_WIDTH, 8, width of each stored word
FIFO_DEPTH, 16, number of entries; power of two, >= 2
ADDR_WIDTH, 4, log2(FIFO_DEPTH); pointers are ADDR_WIDTH+1 bits
AF_LEVEL, 14, ALMOST_FULL asserted when COUNT >= AF_LEVEL (1..FIFO_DEPTH)
AE_LEVEL, 2, ALMOST_EMPTY asserted when COUNT <= AE_LEVEL (0..FIFO_DEPTH-1)
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through

Ports:
CLK  input  1  single clock; all logic on rising edge
RST  input  1  synchronous, active-low reset
WR_EN  input  1  write request
WR_DATA  input  DATA_WIDTH  write data
RD_EN  input  1  read request (pop)
RD_DATA  output  DATA_WIDTH  read data
RD_VALID  output  1  RD_DATA qualifier
FULL  output  1  no free entries
EMPTY  output  1  no stored entries
ALMOST_FULL  output  1  COUNT >= AF_LEVEL
ALMOST_EMPTY  output  1  COUNT <= AE_LEVEL
COUNT  output  ADDR_WIDTH+1  current number of stored words (0..FIFO_DEPTH)
OVERFLOW  output  1  sticky: write attempted while FULL
UNDERFLOW  output  1  sticky: read attempted while EMPTY
CLR_ERR  input  1  clears OVERFLOW/UNDERFLOW

Behaviour:
Reset (RST=0 at a rising edge):
- pointers = 0, COUNT = 0, EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0.
- OVERFLOW = 0, UNDERFLOW = 0, RD_VALID = 0, RD_DATA = 0.
- Memory array is not reset; contents are undefined.
- Reset mid-operation discards all stored data. The first cycle after reset behaves as an empty FIFO.

Pointers and status:
- wr_ptr and rd_ptr are (ADDR_WIDTH+1)-bit binary counters. The low ADDR_WIDTH bits address memory; the MSB toggles on wrap.
- Pointers wrap naturally at 2*FIFO_DEPTH.
- EMPTY = (wr_ptr == rd_ptr).
- FULL = MSBs differ and low bits are equal.
- COUNT, FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY are registered. They are computed from next-state pointers, so all reflect the same post-edge state with no skew.

Accepting requests:
- A write is accepted iff WR_EN=1 and FULL=0, using the flag value before the edge. Data is stored at wr_ptr and wr_ptr increments.
- A read is accepted iff RD_EN=1 and EMPTY=0, using the flag value before the edge. rd_ptr increments.
- Simultaneous accepted read and write: COUNT is unchanged and both pointers advance.
- FULL with WR_EN=1 and RD_EN=1: the read is accepted, the write is rejected, and OVERFLOW is set. COUNT becomes FIFO_DEPTH-1.
- EMPTY with both requests: the write is accepted, the read is rejected, and UNDERFLOW is set. COUNT becomes 1.
- A rejected request never changes any pointer or memory.

Error flags:
- OVERFLOW and UNDERFLOW are set by a rejected request and held until CLR_ERR=1.
- If a new error event coincides with CLR_ERR, the set wins.

Standard read mode (FWFT=0):
- An accepted read registers mem[rd_addr] into RD_DATA on that edge, with RD_VALID=1 for exactly the following cycle.
- Read latency is 1 cycle.
- Without an accepted read, RD_VALID=0 and RD_DATA holds its last value.

FWFT read mode (FWFT=1):
- RD_VALID = !EMPTY.
- RD_DATA is the head word, valid in the same cycle RD_VALID is high. It comes from an output holding register loaded on the write into an empty FIFO or on a pop.
- RD_EN acts as acknowledge: it pops the head, and the next word, if any, appears after the edge.
- Write-into-empty: RD_VALID rises 1 cycle after the write edge.

Throughput and sizing:
- Sustained 1 write + 1 read per cycle, including at pointer wrap-around.
- Threshold parameters outside their legal range are a configuration error and are not checked at runtime.

Test Plan:
1. Reset with stale pointers, FWFT=0, FIFO_DEPTH=8 -> COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, errors 0, RD_VALID=0 on the first cycle after RST deasserts.
2. Write 0x01..0x08 (DEPTH=8, AF_LEVEL=6) -> ALMOST_FULL rises after the 6th write. FULL and COUNT=8 after the 8th. A 9th write with 0x09 sets OVERFLOW and COUNT stays 8. Reading 8 times returns 0x01..0x08 in order, each with RD_VALID one cycle after RD_EN; the final EMPTY=1.
3. Keep COUNT=4, then do 20 cycles of simultaneous write/read with an incrementing pattern crossing the pointer wrap -> COUNT stays 4. Output order is preserved and FULL/EMPTY never assert.
4. FULL, WR_EN=RD_EN=1 -> the read returns the oldest word, the write is dropped, OVERFLOW=1, COUNT=7. EMPTY, both asserted -> the write is stored, UNDERFLOW=1, COUNT=1.
5. OVERFLOW=1, then CLR_ERR=1 with no fault -> OVERFLOW=0 next cycle. CLR_ERR together with a new overflowing write -> OVERFLOW stays 1.
6. FWFT=1: write 0xA5 into empty -> RD_VALID=1 and RD_DATA=0xA5 one cycle later without RD_EN. Write 0x5A, then pulse RD_EN -> RD_DATA=0x5A next cycle. A further RD_EN -> RD_VALID=0, EMPTY=1.
